spi_frame_slave: RTL and testbench

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_frame_slave_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 30 +++
 rtl/spi_frame_slave.sv | 121 ++++++++++++
 tb/tb_spi_frame_slave.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/spi_frame_slave_pkg.sv
// Shared constants and FSM encoding for the SPI frame slave.
package spi_frame_slave_pkg;

  localparam int unsigned FRAME_BITS_DEF = 256;
  localparam int unsigned COUNT_W        = 16;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchronizer with rise/fall pulse detection on the synchronized level.
module spi_sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= STAGES'({chain, din});
      prev  <= chain[STAGES-1];
    end
  end

  assign level  = chain[STAGES-1];
  assign rise_c = level & ~prev;
  assign fall_c = ~level & prev;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 frame slave: receives and transmits one FRAME_BITS word per CS_N low period.
module spi_frame_slave
  import spi_frame_slave_pkg::*;
#(
  parameter int unsigned FRAME_BITS  = FRAME_BITS_DEF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  SPI_CS_N,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_MOSI,
  output logic                  SPI_MISO,
  input  logic [FRAME_BITS-1:0] TX_DATA,
  output logic [FRAME_BITS-1:0] RX_DATA,
  output logic                  RX_VALID,
  output logic                  FRAME_ERR,
  output logic [COUNT_W-1:0]    FRAME_COUNT
);

  localparam int unsigned CNT_W = $clog2(FRAME_BITS) + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(CLK), .rst(RESET), .din(SPI_CS_N),
    .level(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(CLK), .rst(RESET), .din(SPI_SCLK),
    .level(sclk_lvl), .rise_c(sclk_rise), .fall_c(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(CLK), .rst(RESET), .din(SPI_MOSI),
    .level(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
  );

  state_t                state;
  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;
  logic [CNT_W-1:0]      cnt;
  logic                  done_pend;
  logic                  err_pend;

  // Edges and the TX MSB register are consumed elsewhere or not at all.
  logic unused_sig;
  assign unused_sig = ^{sclk_lvl, mosi_rise, mosi_fall, tx_sr[FRAME_BITS-1]};

  // Frame FSM; end-of-frame results go through one pending stage so outputs
  // appear SYNC_STAGES+2 cycles after the CS_N pin rises.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= WAIT_IDLE;
      tx_sr       <= '0;
      rx_sr       <= '0;
      cnt         <= '0;
      RX_DATA     <= '0;
      FRAME_COUNT <= '0;
      RX_VALID    <= 1'b0;
      FRAME_ERR   <= 1'b0;
      SPI_MISO    <= 1'b0;
      done_pend   <= 1'b0;
      err_pend    <= 1'b0;
    end else begin
      RX_VALID  <= done_pend;
      FRAME_ERR <= err_pend;
      done_pend <= 1'b0;
      err_pend  <= 1'b0;
      if (done_pend) FRAME_COUNT <= FRAME_COUNT + COUNT_W'(1);

      case (state)
        WAIT_IDLE: begin
          SPI_MISO <= 1'b0;
          if (cs_lvl) state <= IDLE;
        end
        IDLE: begin
          SPI_MISO <= 1'b0;
          if (cs_fall) begin
            state    <= SHIFT;
            tx_sr    <= TX_DATA;
            cnt      <= '0;
            SPI_MISO <= TX_DATA[FRAME_BITS-1];
          end
        end
        SHIFT: begin
          // CS_N release wins over any SCLK edge in the same cycle.
          if (cs_rise) begin
            state    <= IDLE;
            SPI_MISO <= 1'b0;
            if (cnt == CNT_FULL) begin
              RX_DATA   <= rx_sr;
              done_pend <= 1'b1;
            end else begin
              err_pend  <= 1'b1;
            end
          end else begin
            if (sclk_rise) begin
              rx_sr <= {rx_sr[FRAME_BITS-2:0], mosi_lvl};
              if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
            end
            if (sclk_fall) begin
              tx_sr    <= {tx_sr[FRAME_BITS-2:0], 1'b0};
              SPI_MISO <= tx_sr[FRAME_BITS-2];
            end
          end
        end
        default: begin
          state    <= WAIT_IDLE;
          SPI_MISO <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: frame table plus reset, wrap and coincident-edge cases.
module tb_spi_frame_slave;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         SPI_CS_N = 1'b1;
  logic         SPI_SCLK = 1'b0;
  logic         SPI_MOSI = 1'b0;
  logic         SPI_MISO;
  logic [255:0] TX_DATA = '0;
  logic [255:0] RX_DATA;
  logic         RX_VALID;
  logic         FRAME_ERR;
  logic [15:0]  FRAME_COUNT;

  always #5 CLK = ~CLK;

  spi_frame_slave dut (
    .CLK(CLK), .RESET(RESET), .SPI_CS_N(SPI_CS_N), .SPI_SCLK(SPI_SCLK),
    .SPI_MOSI(SPI_MOSI), .SPI_MISO(SPI_MISO), .TX_DATA(TX_DATA),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .FRAME_ERR(FRAME_ERR),
    .FRAME_COUNT(FRAME_COUNT)
  );

  typedef struct {
    int           nbits;
    logic [255:0] mosi;
    logic [255:0] tx;
    int           exp_valid;
    int           exp_err;
    logic [255:0] exp_rx;
    logic [15:0]  exp_cnt;
  } vec_t;

  int cyc = 0;
  int nvalid = 0;
  int nerr = 0;
  int valid_cyc = 0;
  int cs_rise_cyc = 0;
  int checks = 0;
  int errors = 0;
  bit both_seen = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (RX_VALID) begin
      nvalid    <= nvalid + 1;
      valid_cyc <= cyc;
    end
    if (FRAME_ERR) nerr <= nerr + 1;
    if (RX_VALID && FRAME_ERR) both_seen <= 1'b1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Mode-0 master at CLK/8; inputs change on negedges, MISO sampled just before each SCLK rise.
  task automatic run_frame(input int nbits, input logic [255:0] mosi, input logic [255:0] tx,
                           input int tx_change_at, input bit coincide, input int reset_at,
                           output logic [255:0] cap);
    cap = '0;
    TX_DATA = tx;
    @(negedge CLK);
    SPI_CS_N = 1'b0;
    repeat (8) @(negedge CLK);
    for (int i = 0; i < nbits; i++) begin
      if (i == tx_change_at) TX_DATA = ~tx;
      if (i == reset_at) begin
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
      end
      SPI_MOSI = (i < 256) ? mosi[255 - i] : 1'b0;
      repeat (4) @(negedge CLK);
      if (i < 256) cap[255 - i] = SPI_MISO;
      SPI_SCLK = 1'b1;
      if (coincide && i == nbits - 1) begin
        SPI_CS_N    = 1'b1;
        cs_rise_cyc = cyc;
      end
      repeat (4) @(negedge CLK);
      SPI_SCLK = 1'b0;
    end
    if (!coincide) begin
      repeat (8) @(negedge CLK);
      SPI_CS_N    = 1'b1;
      cs_rise_cyc = cyc;
    end
    SPI_MOSI = 1'b0;
    repeat (16) @(negedge CLK);
  endtask

  logic [255:0] p_a5, p_3c, p_0123, p_fedc, p_5a, cap;
  vec_t vecs[6];
  int v0, e0;

  initial begin
    p_a5   = {32{8'hA5}};
    p_3c   = {32{8'h3C}};
    p_5a   = {32{8'h5A}};
    p_0123 = {4{64'h0123456789ABCDEF}};
    p_fedc = {4{64'hFEDCBA9876543210}};

    vecs[0] = '{256, p_a5,   p_0123, 1, 0, p_a5,   16'd1};
    vecs[1] = '{255, p_3c,   p_0123, 0, 1, p_a5,   16'd1};
    vecs[2] = '{257, p_3c,   p_0123, 0, 1, p_a5,   16'd1};
    vecs[3] = '{0,   p_3c,   p_0123, 0, 1, p_a5,   16'd1};
    vecs[4] = '{256, p_0123, p_fedc, 1, 0, p_0123, 16'd2};
    vecs[5] = '{256, '1,     '0,     1, 0, '1,     16'd3};

    repeat (3) @(negedge CLK);
    chk("reset rx_data", RX_DATA, '0);
    chk("reset rx_valid", 256'(RX_VALID), '0);
    chk("reset frame_err", 256'(FRAME_ERR), '0);
    chk("reset frame_count", 256'(FRAME_COUNT), '0);
    chk("reset miso", 256'(SPI_MISO), '0);
    RESET = 1'b0;
    repeat (6) @(negedge CLK);

    for (int i = 0; i < 6; i++) begin
      v0 = nvalid;
      e0 = nerr;
      run_frame(vecs[i].nbits, vecs[i].mosi, vecs[i].tx, -1, 1'b0, -1, cap);
      chk($sformatf("row%0d valid_pulses", i), 256'(nvalid - v0), 256'(vecs[i].exp_valid));
      chk($sformatf("row%0d err_pulses", i), 256'(nerr - e0), 256'(vecs[i].exp_err));
      chk($sformatf("row%0d rx_data", i), RX_DATA, vecs[i].exp_rx);
      chk($sformatf("row%0d frame_count", i), 256'(FRAME_COUNT), 256'(vecs[i].exp_cnt));
      chk($sformatf("row%0d idle_miso", i), 256'(SPI_MISO), '0);
      if (vecs[i].nbits == 256)
        chk($sformatf("row%0d miso_bits", i), cap, vecs[i].tx);
      if (i == 0)
        chk("cs_to_valid_latency", 256'(valid_cyc - cs_rise_cyc), 256'(4));
    end

    // Reset mid-frame with CS_N held low: the frame must vanish silently.
    v0 = nvalid;
    e0 = nerr;
    run_frame(256, p_3c, p_0123, -1, 1'b0, 100, cap);
    chk("rst valid_pulses", 256'(nvalid - v0), '0);
    chk("rst err_pulses", 256'(nerr - e0), '0);
    chk("rst frame_count", 256'(FRAME_COUNT), '0);
    chk("rst rx_data", RX_DATA, '0);
    v0 = nvalid;
    run_frame(256, p_5a, p_fedc, -1, 1'b0, -1, cap);
    chk("post_rst valid_pulses", 256'(nvalid - v0), 256'(1));
    chk("post_rst rx_data", RX_DATA, p_5a);
    chk("post_rst frame_count", 256'(FRAME_COUNT), 256'(1));
    chk("post_rst miso_bits", cap, p_fedc);

    // Frame counter wrap from 0xFFFF.
    @(negedge CLK);
    force dut.FRAME_COUNT = 16'hFFFF;
    @(negedge CLK);
    release dut.FRAME_COUNT;
    repeat (2) @(negedge CLK);
    v0 = nvalid;
    run_frame(256, p_a5, p_0123, -1, 1'b0, -1, cap);
    chk("wrap valid_pulses", 256'(nvalid - v0), 256'(1));
    chk("wrap frame_count", 256'(FRAME_COUNT), '0);
    chk("wrap rx_data", RX_DATA, p_a5);

    // TX_DATA changed mid-frame; CS_N rises together with the 256th SCLK rise.
    v0 = nvalid;
    e0 = nerr;
    run_frame(256, p_3c, p_fedc, 128, 1'b1, -1, cap);
    chk("coinc miso_bits", cap, p_fedc);
    chk("coinc err_pulses", 256'(nerr - e0), 256'(1));
    chk("coinc valid_pulses", 256'(nvalid - v0), '0);
    chk("coinc rx_data", RX_DATA, p_a5);
    chk("coinc frame_count", 256'(FRAME_COUNT), '0);

    chk("valid_and_err_together", 256'(both_seen), '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
